// File: rtl/puf_crp_pkg.sv
// Shared types, widths and helpers for the PUF challenge/response host.
package puf_crp_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned CRP_WIDTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX_HI = 3'd1,
        ST_TX_LO = 3'd2,
        ST_RX_HI = 3'd3,
        ST_RX_LO = 3'd4,
        ST_EMIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Binary to reflected Gray code.
    function automatic logic [CRP_WIDTH-1:0] b2g(input logic [CRP_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit start re-check,
// centre sampling and stop-bit framing check. valid/frame_err are single-cycle
// strobes raised on the stop-bit centre sample; data holds the last byte.
module uart_rx_byte
    import puf_crp_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic                      rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]                st_q, st_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;

    // Synchronizer, edge history and receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            st_q      <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // Frame sequencing: edge detect, start re-check, data shift, stop check.
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid     = 1'b0;
        frame_err = 1'b0;
        case (st_q)
            R_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    st_d = R_START;
                end
            end
            R_START: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d = '0;
                    st_d  = rx_sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        st_d = R_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            R_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    valid     = rx_sync_q;
                    frame_err = !rx_sync_q;
                    st_d      = R_IDLE;
                end
            end
            default: st_d = R_IDLE;
        endcase
    end

    assign data = shift_q;

endmodule

// File: rtl/puf_crp_host.sv
// Host-side PUF challenge/response collector over a 16-bit UART link.
// Sends each challenge as two 8N1 bytes (high first), collects the two-byte
// response, and emits the pair; response timeouts retry up to MAX_RETRY times.
// Optional macro PUF_CRP_GRAY_EN: crp_challenge reports the Gray code of the
// transmitted challenge instead of the binary value.
module puf_crp_host
    import puf_crp_pkg::*;
#(
    parameter int unsigned    CLKS_PER_BIT = 868,
    parameter logic [15:0]    CHAL_START   = 16'h0000,
    parameter int unsigned    CHAL_COUNT   = 16,
    parameter int unsigned    TIMEOUT_CYC  = 2_000_000,
    parameter int unsigned    MAX_RETRY    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 done,
    output logic                 abort,
    output logic                 crp_valid,
    output logic [CRP_WIDTH-1:0] crp_challenge,
    output logic [CRP_WIDTH-1:0] crp_response,
    output logic [CRP_WIDTH-1:0] crp_index
);

    localparam int unsigned BIT_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned FRAME_BITS = UART_DATA_BITS + 2;
    localparam int unsigned FRAME_W    = $clog2(FRAME_BITS);
    localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RETRY_W    = $clog2(MAX_RETRY + 2);

    state_e                    state_q, state_d;
    logic [CRP_WIDTH-1:0]      chal_q, chal_d;
    logic [CRP_WIDTH-1:0]      idx_q, idx_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [UART_DATA_BITS-1:0] resp_hi_q, resp_hi_d;
    logic [BIT_CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [FRAME_W-1:0]        tx_bit_q, tx_bit_d;
    logic                      uart_tx_q, uart_tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      abort_q, abort_d;
    logic                      crp_valid_q, crp_valid_d;
    logic [CRP_WIDTH-1:0]      crp_chal_q, crp_chal_d;
    logic [CRP_WIDTH-1:0]      crp_resp_q, crp_resp_d;
    logic [CRP_WIDTH-1:0]      crp_idx_q, crp_idx_d;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_frame_err;
    logic                      rx_ok;
    logic [UART_DATA_BITS-1:0] tx_byte;
    logic [FRAME_BITS-1:0]     tx_frame;
    logic [CRP_WIDTH-1:0]      chal_report;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    // A byte is only accepted when its stop bit was good.
    assign rx_ok = rx_valid & ~rx_frame_err;

`ifdef PUF_CRP_GRAY_EN
    assign chal_report = b2g(chal_q);
`else
    assign chal_report = chal_q;
`endif

    // State and output registers; reset drives the line idle high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            chal_q      <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            resp_hi_q   <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            uart_tx_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            crp_valid_q <= 1'b0;
            crp_chal_q  <= '0;
            crp_resp_q  <= '0;
            crp_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            chal_q      <= chal_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            resp_hi_q   <= resp_hi_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            uart_tx_q   <= uart_tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            crp_valid_q <= crp_valid_d;
            crp_chal_q  <= crp_chal_d;
            crp_resp_q  <= crp_resp_d;
            crp_idx_q   <= crp_idx_d;
        end
    end

    // Run sequencing, inline transmit serializer and response timeout.
    always_comb begin
        state_d     = state_q;
        chal_d      = chal_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        resp_hi_d   = resp_hi_q;
        tx_cnt_d    = '0;
        tx_bit_d    = '0;
        uart_tx_d   = 1'b1;
        busy_d      = busy_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        crp_valid_d = 1'b0;
        crp_chal_d  = crp_chal_q;
        crp_resp_d  = crp_resp_q;
        crp_idx_d   = crp_idx_q;
        tx_byte     = chal_q[15:8];
        tx_frame    = '1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d  = CHAL_START;
                    idx_d   = '0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_TX_HI;
                end
            end
            ST_TX_HI, ST_TX_LO: begin
                tx_byte   = (state_q == ST_TX_HI) ? chal_q[15:8] : chal_q[7:0];
                tx_frame  = {1'b1, tx_byte, 1'b0};
                uart_tx_d = tx_frame[tx_bit_q];
                tx_cnt_d  = tx_cnt_q + BIT_CNT_W'(1);
                tx_bit_d  = tx_bit_q;
                if (tx_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == FRAME_W'(FRAME_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (state_q == ST_TX_HI) begin
                            state_d = ST_TX_LO;
                        end else begin
                            tmo_d   = '0;
                            state_d = ST_RX_HI;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + FRAME_W'(1);
                    end
                end
            end
            ST_RX_HI, ST_RX_LO: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (rx_ok) begin
                    if (state_q == ST_RX_HI) begin
                        resp_hi_d = rx_data;
                        state_d   = ST_RX_LO;
                    end else begin
                        crp_valid_d = 1'b1;
                        crp_chal_d  = chal_report;
                        crp_resp_d  = {resp_hi_q, rx_data};
                        crp_idx_d   = idx_q;
                        state_d     = ST_EMIT;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_TX_HI;
                    end else begin
                        done_d  = 1'b1;
                        abort_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EMIT: begin
                idx_d   = idx_q + CRP_WIDTH'(1);
                retry_d = '0;
                chal_d  = chal_q + CRP_WIDTH'(1);
                if (({1'b0, idx_q} + 17'd1) == 17'(CHAL_COUNT)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_TX_HI;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign uart_tx       = uart_tx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign abort         = abort_q;
    assign crp_valid     = crp_valid_q;
    assign crp_challenge = crp_chal_q;
    assign crp_response  = crp_resp_q;
    assign crp_index     = crp_idx_q;

endmodule

// File: tb/tb_puf_crp_host.sv
// Scoreboard bench for puf_crp_host: expected bytes/pairs/done events are
// queued by the stimulus; independent monitors decode uart_tx and watch the
// crp/done strobes, popping and comparing as the DUT produces them.
`timescale 1ns/1ps
module tb_puf_crp_host;

    localparam int unsigned CPB   = 8;
    localparam int unsigned TMO   = 600;
    localparam int unsigned MAXR  = 3;
    localparam int unsigned NPAIR = 3;
    localparam logic [15:0] CST   = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        uart_rx;
    logic        uart_tx;
    logic        busy;
    logic        done;
    logic        abort;
    logic        crp_valid;
    logic [15:0] crp_challenge;
    logic [15:0] crp_response;
    logic [15:0] crp_index;

    always #5 clk = ~clk;

    puf_crp_host #(
        .CLKS_PER_BIT (CPB),
        .CHAL_START   (CST),
        .CHAL_COUNT   (NPAIR),
        .TIMEOUT_CYC  (TMO),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .done          (done),
        .abort         (abort),
        .crp_valid     (crp_valid),
        .crp_challenge (crp_challenge),
        .crp_response  (crp_response),
        .crp_index     (crp_index)
    );

    int compared   = 0;
    int mismatched = 0;
    int tx_count   = 0;
    int done_count = 0;

    logic [7:0]  exp_tx_q[$];
    logic [47:0] exp_crp_q[$];
    logic        exp_done_q[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got event expected none / in time", name);
    endtask

    function automatic logic [15:0] exp_chal(input logic [15:0] c);
`ifdef PUF_CRP_GRAY_EN
        return c ^ {1'b0, c[15:1]};
`else
        return c;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device side: one 8N1 frame on uart_rx, optionally with a bad stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
        if (!stop_bit) begin
            uart_rx = 1'b1;
            tick(CPB);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 48'(busy), 48'd1);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int c;
        c = 0;
        while (tx_count < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (tx_count < n) flag("wait_tx_timeout");
    endtask

    task automatic wait_done(input int n, input int budget);
        int c;
        c = 0;
        while (done_count < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (done_count < n) flag("wait_done_timeout");
    endtask

    task automatic push_run(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
        logic [15:0] c;
        logic [15:0] r [3];
        r[0] = r0; r[1] = r1; r[2] = r2;
        c = CST;
        for (int k = 0; k < 3; k++) begin
            exp_tx_q.push_back(c[15:8]);
            exp_tx_q.push_back(c[7:0]);
            exp_crp_q.push_back({exp_chal(c), r[k], 16'(k)});
            c = c + 16'd1;
        end
        exp_done_q.push_back(1'b0);
    endtask

    // Answers each challenge once it has gone out; optional line noise first.
    task automatic respond_run(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                               input int base, input bit noise);
        logic [15:0] r [3];
        r[0] = r0; r[1] = r1; r[2] = r2;
        for (int k = 0; k < 3; k++) begin
            wait_tx(base + 2 * (k + 1), 2000);
            tick(CPB);
            if (noise && k == 0) begin
                uart_rx = 1'b0;
                tick(2);
                uart_rx = 1'b1;
                tick(10);
                send_byte(8'h11, 1'b0);
            end
            send_byte(r[k][15:8], 1'b1);
            send_byte(r[k][7:0], 1'b1);
        end
    endtask

    // uart_tx decoder: samples at bit centres on the falling clock edge.
    initial begin : tx_mon
        logic [7:0] b;
        logic       ok;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                ok = 1'b1;
                for (int k = 0; k < int'(CPB / 2); k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ok = 1'b0;
                end
                if (uart_tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < int'(CPB); k++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) ok = 1'b0;
                    end
                    b[i] = uart_tx;
                end
                for (int k = 0; k < int'(CPB); k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ok = 1'b0;
                end
                stopb = uart_tx;
                if (ok) begin
                    tx_count++;
                    check("tx_stop_bit", 48'(stopb), 48'd1);
                    if (exp_tx_q.size() == 0) flag("tx_extra_byte");
                    else check("tx_byte", 48'(b), 48'(exp_tx_q.pop_front()));
                end
            end
        end
    end

    // Pair monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && crp_valid === 1'b1) begin
            if (exp_crp_q.size() == 0) begin
                flag("crp_extra_valid");
            end else begin
                logic [47:0] e;
                e = exp_crp_q.pop_front();
                check("crp_challenge", 48'(crp_challenge), 48'(e[47:32]));
                check("crp_response", 48'(crp_response), 48'(e[31:16]));
                check("crp_index", 48'(crp_index), 48'(e[15:0]));
            end
        end
    end

    // End-of-run monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                done_count++;
                if (exp_done_q.size() == 0) begin
                    flag("done_extra");
                end else begin
                    check("abort_with_done", 48'(abort), 48'(exp_done_q.pop_front()));
                    check("busy_at_done", 48'(busy), 48'd0);
                end
            end else if (abort === 1'b1) begin
                flag("abort_without_done");
            end
        end
    end

    initial begin
        int base;
        int dbase;
        rst_n   = 1'b0;
        start   = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        check("rst_uart_tx", 48'(uart_tx), 48'd1);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_done", 48'(done), 48'd0);
        check("rst_abort", 48'(abort), 48'd0);
        check("rst_crp_valid", 48'(crp_valid), 48'd0);
        check("rst_crp_challenge", 48'(crp_challenge), 48'd0);
        check("rst_crp_response", 48'(crp_response), 48'd0);
        check("rst_crp_index", 48'(crp_index), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);

        // Run 1: wrap FFFF->0000->0001, glitch and bad frame before first response.
        push_run(16'hABCD, 16'h1234, 16'hBEEF);
        base = tx_count;
        pulse_start();
        respond_run(16'hABCD, 16'h1234, 16'hBEEF, base, 1'b1);
        wait_done(1, 2000);
        tick(5);
        check("hold_crp_response", 48'(crp_response), 48'hBEEF);
        check("hold_crp_index", 48'(crp_index), 48'd2);
        check("idle_busy", 48'(busy), 48'd0);

        // Run 2: silent device, four transmissions then abort.
        for (int i = 0; i < int'(MAXR) + 1; i++) begin
            exp_tx_q.push_back(CST[15:8]);
            exp_tx_q.push_back(CST[7:0]);
        end
        exp_done_q.push_back(1'b1);
        base = tx_count;
        pulse_start();
        wait_done(2, 6000);
        tick(20);
        check("retry_tx_count", 48'(tx_count - base), 48'(2 * (MAXR + 1)));

        // Run 3: reset during the low challenge byte, then a clean restart.
        exp_tx_q.push_back(CST[15:8]);
        base  = tx_count;
        dbase = done_count;
        pulse_start();
        wait_tx(base + 1, 500);
        tick(20);
        rst_n = 1'b0;
        #1;
        check("midreset_uart_tx", 48'(uart_tx), 48'd1);
        check("midreset_busy", 48'(busy), 48'd0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(100);
        check("no_done_after_reset", 48'(done_count), 48'(dbase));
        push_run(16'h0001, 16'h8000, 16'h5A5A);
        base = tx_count;
        pulse_start();
        respond_run(16'h0001, 16'h8000, 16'h5A5A, base, 1'b0);
        wait_done(dbase + 1, 2000);
        tick(20);

        check("left_tx", 48'(exp_tx_q.size()), 48'd0);
        check("left_crp", 48'(exp_crp_q.size()), 48'd0);
        check("left_done", 48'(exp_done_q.size()), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/puf_crp_host.md
# puf_crp_host

Host-side challenge–response collector: the far end of the 16-bit UART PUF link. It sequences a range of 16-bit challenges, transmits each as two 8N1 UART bytes, captures the two-byte 16-bit response that comes back, and presents each challenge/response pair on a valid strobe for logging. A response timeout triggers a bounded retry.

## Interface
- CLKS_PER_BIT, 868 — clk cycles per UART bit; 100 MHz / 115200.
- CHAL_START, 16'h0000 — first challenge, binary.
- CHAL_COUNT, 16 — pairs collected per run; range 1..65535.
- TIMEOUT_CYC, 2_000_000 — cycle limit for a complete response.
- MAX_RETRY, 3 — resends per challenge before the run aborts.
- clk  in  1  system clock
- rst_n  in  1  reset; active-low, asynchronous (already decided)
- start  in  1  level; sampled in IDLE; starts a run
- uart_rx  in  1  serial input from the device, idle high
- uart_tx  out  1  serial output to the device, idle high
- busy  out  1  high from run start until DONE
- done  out  1  one-cycle pulse at the end of a run
- abort  out  1  one-cycle pulse together with done when retries are exhausted
- crp_valid  out  1  one-cycle pulse marking a captured pair
- crp_challenge  out  16  challenge of the captured pair
- crp_response  out  16  response of the captured pair
- crp_index  out  16  zero-based pair count within the run

## Operation
- Reset: uart_tx=1. busy, done, abort and crp_valid are 0. crp_challenge, crp_response and crp_index are 0. The FSM enters IDLE.
- FSM states: IDLE, TX_HI, TX_LO, RX_HI, RX_LO, EMIT, DONE.
- IDLE: when start=1, load chal=CHAL_START, idx=0, retry=0; go to TX_HI.
- TX_HI/TX_LO: send chal[15:8], then chal[7:0].
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1.
  - There is no gap between the two frames.
- RX_HI/RX_LO: receive the high response byte, then the low response byte.
  - The timeout counter starts at entry to RX_HI and is not reset by RX_LO.
- Timeout (counter reaches TIMEOUT_CYC):
  - If retry<MAX_RETRY: increment retry and return to TX_HI with the same challenge.
  - Otherwise: go to DONE and pulse abort.
- EMIT: pulse crp_valid and update the three crp_* outputs. Then:
  - idx increments and retry is cleared.
  - chal increments, wrapping at 16'hFFFF to 16'h0000.
  - If idx+1 equals CHAL_COUNT, go to DONE; otherwise go to TX_HI.
- DONE: pulse done, clear busy, return to IDLE. A new run needs start sampled in IDLE; a held start begins the next run immediately.
- RX framing:
  - Falling edge on a 2-flop-synchronized uart_rx.
  - Start bit re-checked at mid-bit (CLKS_PER_BIT/2). A false start is discarded.
  - Data sampled at bit centres.
  - Stop bit = 0 is a framing error: the byte is discarded, reception re-arms, and the timeout keeps running.
- Bytes that arrive outside RX_HI/RX_LO are ignored.
- start is ignored while busy.

## Timing
- One UART frame is 10·CLKS_PER_BIT cycles. uart_tx falls on the cycle after the FSM enters TX_HI.
- crp_valid asserts exactly 1 cycle after the stop-bit centre sample of the low response byte.
- The crp_* outputs hold their values until the next EMIT.
- done asserts on the cycle after the last EMIT, or after the final timeout.
- busy rises on the cycle after start is sampled.
- Asserting rst_n low mid-frame forces uart_tx high immediately (asynchronously) and abandons the run. No done pulse is produced.

## Configuration
- PUF_CRP_GRAY_EN defined: crp_challenge reports the Gray code of the transmitted challenge, chal ^ (chal>>1). This is the value the device's PUF actually evaluates.
- Without it: crp_challenge reports the binary challenge as transmitted.
- The transmitted bytes are identical in both cases.

## Structure
- Package puf_crp_pkg holds:
  - the FSM state enum;
  - the constants UART_DATA_BITS=8 and CRP_WIDTH=16;
  - the b2g function.
- Sub-module uart_rx_byte holds the synchronizer, mid-bit sampler and framing check. Its outputs are data[7:0], valid and frame_err.
- The transmit serializer lives inline in the top, since it is driven directly by the FSM.

## Test plan
- CHAL_START=16'h0005, CHAL_COUNT=2, device model echoing 16'hABCD:
  - uart_tx carries 8'h00, 8'h05, then 8'h00, 8'h06.
  - Two crp_valid pulses with response 16'hABCD and crp_index 0, then 1.
  - Then a single done pulse.
- PUF_CRP_GRAY_EN defined, challenge 16'h0006: crp_challenge=16'h0005; transmitted bytes are 8'h00, 8'h06.
- Device silent, MAX_RETRY=3:
  - Exactly 4 transmissions of the same challenge.
  - Then done and abort in the same cycle, and no crp_valid.
- CHAL_START=16'hFFFF, CHAL_COUNT=2: second transmitted challenge is 16'h0000.
- Stimulus:
  - a glitch on uart_rx shorter than CLKS_PER_BIT/2;
  - a response frame with stop bit 0;
  - a correct response before the timeout.
  Required response:
  - no spurious byte from the glitch;
  - the bad frame is dropped;
  - crp_valid carries the correct response.
- rst_n pulsed low during TX_LO:
  - uart_tx=1 and busy=0 immediately, with no done;
  - a fresh start restarts from CHAL_START.
